// File: rtl/calcsys_pkg.sv
// Shared definitions for the calculator control unit: state encoding,
// opcode constants, operation classes and result-mux select codes.
package calcsys_pkg;

   // State encoding; the numeric values are visible on the cs output.
   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_LOAD      = 4'd1,
      ST_DECODE    = 4'd2,
      ST_CALC_GO   = 4'd3,
      ST_CALC_WAIT = 4'd4,
      ST_MUL_WAIT  = 4'd5,
      ST_DIV_GO    = 4'd6,
      ST_DIV_WAIT  = 4'd7,
      ST_WRITE     = 4'd8,
      ST_DONE      = 4'd9,
      ST_ERR       = 4'd10
   } state_t;

   // Which execution path an opcode takes.
   typedef enum logic [1:0] {
      CLS_PASS = 2'd0,
      CLS_CALC = 2'd1,
      CLS_MUL  = 2'd2,
      CLS_DIV  = 2'd3
   } op_class_t;

   localparam logic [2:0] OP_PASS_X = 3'b000;
   localparam logic [2:0] OP_PASS_Y = 3'b001;
   localparam logic [2:0] OP_ADD    = 3'b010;
   localparam logic [2:0] OP_SUB    = 3'b011;
   localparam logic [2:0] OP_AND    = 3'b100;
   localparam logic [2:0] OP_XOR    = 3'b101;
   localparam logic [2:0] OP_MUL    = 3'b110;
   localparam logic [2:0] OP_DIV    = 3'b111;

   // Result mux select codes (shared by sel_lo and sel_hi).
   localparam logic [1:0] SEL_PASS = 2'b00;
   localparam logic [1:0] SEL_CALC = 2'b01;
   localparam logic [1:0] SEL_MUL  = 2'b10;
   localparam logic [1:0] SEL_DIV  = 2'b11;

   // True for the states in which the result selects follow op.
   function automatic logic sel_window(input state_t s);
      return (s == ST_DECODE)    || (s == ST_CALC_GO) ||
             (s == ST_CALC_WAIT) || (s == ST_MUL_WAIT) ||
             (s == ST_DIV_GO)    || (s == ST_DIV_WAIT) ||
             (s == ST_WRITE);
   endfunction

endpackage

// File: rtl/calcsys_control_unit_op_decode.sv
// Combinational opcode decoder: op -> class, result selects, pass select
// and small-calculator operation.
module calcsys_op_decode
   import calcsys_pkg::*;
(
   input  logic [2:0] op,
   output op_class_t  op_class,
   output logic [1:0] sel_lo,
   output logic [1:0] sel_hi,
   output logic       sel_p,
   output logic [1:0] op_calc
);

   // Map the opcode to its path and mux selects.
   always_comb begin
      op_class = CLS_PASS;
      sel_lo   = SEL_PASS;
      sel_hi   = SEL_PASS;
      sel_p    = 1'b0;
      // add/sub/and/xor sit at 2..5, so subtracting 2 gives the calc op.
      op_calc  = op[1:0] - 2'd2;
      case (op)
         OP_PASS_X, OP_PASS_Y: begin
            op_class = CLS_PASS;
            sel_p    = op[0];
         end
         OP_ADD, OP_SUB, OP_AND, OP_XOR: begin
            op_class = CLS_CALC;
            sel_lo   = SEL_CALC;
            sel_hi   = SEL_CALC;
         end
         OP_MUL: begin
            op_class = CLS_MUL;
            sel_lo   = SEL_MUL;
            sel_hi   = SEL_MUL;
         end
         default: begin
            op_class = CLS_DIV;
            sel_lo   = SEL_DIV;
            sel_hi   = SEL_DIV;
         end
      endcase
   end

endmodule

// File: rtl/calcsys_control_unit.sv
// Calculator control unit: sequences operand load, opcode decode, sub-unit
// start/wait and result write-back. All outputs are Moore (state, plus op
// for the selects). Optional wait-state watchdog: CALCSYS_CTRL_TIMEOUT_EN.
module calcsys_control_unit
   import calcsys_pkg::*;
#(
   parameter int MUL_LAT        = 2,
   parameter int TIMEOUT_CYCLES = 16
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       go,
   input  logic [2:0] op,
   input  logic       done_calc,
   input  logic       done_div,
   input  logic       err_flag,
   output logic       x_en,
   output logic       y_en,
   output logic       f_en,
   output logic       hi_en,
   output logic       lo_en,
   output logic [1:0] sel_lo,
   output logic [1:0] sel_hi,
   output logic [1:0] op_calc,
   output logic       sel_p,
   output logic       go_calc,
   output logic       go_div,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [3:0] cs
);

   localparam logic [3:0] MUL_LAST = 4'(MUL_LAT - 1);

   state_t     state_reg, state_next;
   logic [3:0] mul_cnt_reg;
   logic       wd_expired;

   op_class_t  dec_class;
   logic [1:0] dec_sel_lo, dec_sel_hi, dec_op_calc;
   logic       dec_sel_p;

   calcsys_op_decode u_op_decode (
      .op       (op),
      .op_class (dec_class),
      .sel_lo   (dec_sel_lo),
      .sel_hi   (dec_sel_hi),
      .sel_p    (dec_sel_p),
      .op_calc  (dec_op_calc)
   );

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) state_reg <= ST_IDLE;
      else      state_reg <= state_next;
   end

   // Multiplier latency counter: counts cycles spent in MUL_WAIT, zero elsewhere.
   always_ff @(posedge clk) begin
      if (!rst)
         mul_cnt_reg <= 4'd0;
      else if (state_reg == ST_MUL_WAIT && state_next == ST_MUL_WAIT)
         mul_cnt_reg <= mul_cnt_reg + 4'd1;
      else
         mul_cnt_reg <= 4'd0;
   end

`ifdef CALCSYS_CTRL_TIMEOUT_EN
   localparam int             WD_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   logic [WD_W-1:0] wd_cnt_reg;

   // Watchdog: counts consecutive wait-state cycles; restarts on every entry.
   always_ff @(posedge clk) begin
      if (!rst)
         wd_cnt_reg <= '0;
      else if ((state_reg == ST_CALC_WAIT && state_next == ST_CALC_WAIT) ||
               (state_reg == ST_DIV_WAIT  && state_next == ST_DIV_WAIT))
         wd_cnt_reg <= wd_cnt_reg + 1'b1;
      else
         wd_cnt_reg <= '0;
   end

   assign wd_expired = (wd_cnt_reg == WD_LAST);
`else
   // Without the watchdog the wait states never time out.
   assign wd_expired = 1'b0;
`endif

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:      if (go) state_next = err_flag ? ST_ERR : ST_LOAD;
         ST_LOAD:      state_next = ST_DECODE;
         ST_DECODE: begin
            case (dec_class)
               CLS_PASS: state_next = ST_WRITE;
               CLS_CALC: state_next = ST_CALC_GO;
               CLS_MUL:  state_next = ST_MUL_WAIT;
               default:  state_next = ST_DIV_GO;
            endcase
         end
         ST_CALC_GO:   state_next = ST_CALC_WAIT;
         ST_CALC_WAIT: begin
            if (done_calc)       state_next = ST_WRITE;
            else if (wd_expired) state_next = ST_ERR;
         end
         ST_MUL_WAIT:  if (mul_cnt_reg == MUL_LAST) state_next = ST_WRITE;
         ST_DIV_GO:    state_next = ST_DIV_WAIT;
         ST_DIV_WAIT: begin
            if (done_div)        state_next = ST_WRITE;
            else if (wd_expired) state_next = ST_ERR;
         end
         ST_WRITE:     state_next = ST_DONE;
         ST_DONE:      state_next = ST_IDLE;
         ST_ERR:       if (!go) state_next = ST_IDLE;
         default:      state_next = ST_IDLE;
      endcase
   end

   // Moore output decode; selects follow op only inside the decode..write window.
   always_comb begin
      x_en    = 1'b0;
      y_en    = 1'b0;
      f_en    = 1'b0;
      hi_en   = 1'b0;
      lo_en   = 1'b0;
      go_calc = 1'b0;
      go_div  = 1'b0;
      done    = 1'b0;
      error   = 1'b0;
      sel_lo  = 2'b00;
      sel_hi  = 2'b00;
      op_calc = 2'b00;
      sel_p   = 1'b0;
      busy    = (state_reg != ST_IDLE);
      cs      = state_reg;
      case (state_reg)
         ST_LOAD: begin
            x_en = 1'b1;
            y_en = 1'b1;
            f_en = 1'b1;
         end
         ST_CALC_GO: go_calc = 1'b1;
         ST_DIV_GO:  go_div  = 1'b1;
         ST_WRITE: begin
            hi_en = 1'b1;
            lo_en = 1'b1;
         end
         ST_DONE:    done  = 1'b1;
         ST_ERR:     error = 1'b1;
         default: ;
      endcase
      if (sel_window(state_reg)) begin
         sel_lo  = dec_sel_lo;
         sel_hi  = dec_sel_hi;
         op_calc = dec_op_calc;
         sel_p   = dec_sel_p;
      end
   end

endmodule

// File: tb/tb_calcsys_control_unit.sv
// Self-checking bench for calcsys_control_unit: directed vector table,
// hand-written corner sequences and a randomized schedule-based model.
module tb_calcsys_control_unit;
   import calcsys_pkg::*;

   localparam int MUL_LAT = 2;
   localparam int TMO     = 16;

   logic       clk = 1'b0;
   logic       rst, go, done_calc, done_div, err_flag;
   logic [2:0] op;
   logic       x_en, y_en, f_en, hi_en, lo_en, sel_p, go_calc, go_div, busy, done, error;
   logic [1:0] sel_lo, sel_hi, op_calc;
   logic [3:0] cs;

   int n_tests = 0;
   int n_fail  = 0;

   calcsys_control_unit #(.MUL_LAT(MUL_LAT), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .go(go), .op(op), .done_calc(done_calc),
      .done_div(done_div), .err_flag(err_flag), .x_en(x_en), .y_en(y_en),
      .f_en(f_en), .hi_en(hi_en), .lo_en(lo_en), .sel_lo(sel_lo),
      .sel_hi(sel_hi), .op_calc(op_calc), .sel_p(sel_p), .go_calc(go_calc),
      .go_div(go_div), .busy(busy), .done(done), .error(error), .cs(cs)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not finish, got running required finished");
      $fatal(1, "timeout");
   end

   logic [20:0] act_vec;
   assign act_vec = {x_en, y_en, f_en, hi_en, lo_en, sel_lo, sel_hi, op_calc,
                     sel_p, go_calc, go_div, busy, done, error, cs};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected outputs for a state, from the output rules: enables/pulses by
   // state, selects from op in the decode..write window.
   function automatic logic [20:0] exp_vec(input state_t st, input logic [2:0] o);
      logic       win;
      logic [1:0] sl, oc;
      logic       sp;
      win = st inside {ST_DECODE, ST_CALC_GO, ST_CALC_WAIT, ST_MUL_WAIT,
                       ST_DIV_GO, ST_DIV_WAIT, ST_WRITE};
      if (o < 3'd2)       sl = 2'd0;
      else if (o < 3'd6)  sl = 2'd1;
      else if (o == 3'd6) sl = 2'd2;
      else                sl = 2'd3;
      oc = 2'((int'(o) + 2) % 4);
      sp = (o < 3'd2) ? o[0] : 1'b0;
      if (!win) begin
         sl = 2'd0; oc = 2'd0; sp = 1'b0;
      end
      return {st == ST_LOAD, st == ST_LOAD, st == ST_LOAD,
              st == ST_WRITE, st == ST_WRITE, sl, sl, oc, sp,
              st == ST_CALC_GO, st == ST_DIV_GO, st != ST_IDLE,
              st == ST_DONE, st == ST_ERR, 4'(st)};
   endfunction

   // Directed vector table.
   typedef struct {
      logic [2:0] op;
      int         d;          // done delay after go_calc/go_div
      int         done_cyc;   // cycle of done pulse, go sampled in cycle 0
      int         mulw;       // cycles spent in MUL_WAIT
      logic [1:0] sel;
      logic       sp;
      logic [1:0] oc;
   } vec_t;

   // Randomized schedule entry: state expected in a cycle and inputs driven in it.
   typedef struct {
      state_t st;
      bit     g, dc, dd, ef;
   } cyc_t;

   cyc_t sched[$];

   task automatic push(input state_t st, input bit g, input bit dc_req, input bit dd_req, input bit ef);
      cyc_t e;
      e.st = st;
      e.g  = g;
      e.dc = dc_req | ((st != ST_CALC_WAIT) && ($urandom_range(0, 3) == 0));
      e.dd = dd_req | ((st != ST_DIV_WAIT)  && ($urandom_range(0, 3) == 0));
      e.ef = ef;
      sched.push_back(e);
   endtask

   initial begin
      vec_t vecs[7];
      vecs[0] = '{3'd0, 0, 4, 0, 2'd0, 1'b0, 2'b10};
      vecs[1] = '{3'd1, 0, 4, 0, 2'd0, 1'b1, 2'b11};
      vecs[2] = '{3'd2, 3, 8, 0, 2'd1, 1'b0, 2'b00};
      vecs[3] = '{3'd3, 1, 6, 0, 2'd1, 1'b0, 2'b01};
      vecs[4] = '{3'd5, 2, 7, 0, 2'd1, 1'b0, 2'b11};
      vecs[5] = '{3'd6, 0, 4 + MUL_LAT, MUL_LAT, 2'd2, 1'b0, 2'b00};
      vecs[6] = '{3'd7, 3, 8, 0, 2'd3, 1'b0, 2'b01};

      rst = 1'b0; go = 1'b0; op = 3'd0; done_calc = 1'b0; done_div = 1'b0; err_flag = 1'b0;
      repeat (3) tick();
      chk("reset_state", 32'(act_vec), 32'd0);
      rst = 1'b1;
      tick();

      // Directed table: latency, write-back selects and pulse counts per opcode.
      for (int v = 0; v < 7; v++) begin
         int calc_at, div_at, n_done, n_hi, done_cyc, wr_cyc, n_mulw;
         logic [1:0] w_lo, w_hi, w_oc;
         logic w_sp;
         calc_at = -1; div_at = -1; n_done = 0; n_hi = 0; done_cyc = -1; wr_cyc = -1; n_mulw = 0;
         w_lo = 2'd0; w_hi = 2'd0; w_oc = 2'd0; w_sp = 1'b0;
         op = vecs[v].op;
         go = 1'b1;
         for (int c = 1; c <= 40; c++) begin
            tick();
            go = 1'b0;
            if (go_calc) calc_at = c + vecs[v].d;
            if (go_div)  div_at  = c + vecs[v].d;
            if (done) begin
               n_done++;
               if (done_cyc < 0) done_cyc = c;
            end
            if (hi_en) begin
               n_hi++; wr_cyc = c;
               w_lo = sel_lo; w_hi = sel_hi; w_oc = op_calc; w_sp = sel_p;
            end
            if (cs == 4'(ST_MUL_WAIT)) n_mulw++;
            done_calc = (c == calc_at);
            done_div  = (c == div_at);
         end
         chk($sformatf("vec%0d_done_cycle", v), 32'(done_cyc), 32'(vecs[v].done_cyc));
         chk($sformatf("vec%0d_done_count", v), 32'(n_done), 32'd1);
         chk($sformatf("vec%0d_write_cycle", v), 32'(wr_cyc), 32'(vecs[v].done_cyc - 1));
         chk($sformatf("vec%0d_write_count", v), 32'(n_hi), 32'd1);
         chk($sformatf("vec%0d_sel_lo", v), 32'(w_lo), 32'(vecs[v].sel));
         chk($sformatf("vec%0d_sel_hi", v), 32'(w_hi), 32'(vecs[v].sel));
         chk($sformatf("vec%0d_sel_p", v), 32'(w_sp), 32'(vecs[v].sp));
         chk($sformatf("vec%0d_op_calc", v), 32'(w_oc), 32'(vecs[v].oc));
         chk($sformatf("vec%0d_mul_wait", v), 32'(n_mulw), 32'(vecs[v].mulw));
      end

      // Error path: go held 4 cycles with err_flag, IDLE one cycle after go falls.
      begin
         int n_we;
         n_we = 0;
         op = 3'd2; err_flag = 1'b1; go = 1'b1;
         for (int c = 1; c <= 4; c++) begin
            tick();
            chk($sformatf("err_hold_c%0d", c), 32'(error), 32'd1);
            if (hi_en || lo_en) n_we++;
            if (c == 4) go = 1'b0;
         end
         tick();
         if (hi_en || lo_en) n_we++;
         chk("err_release_cs", 32'(cs), 32'(ST_IDLE));
         chk("err_release_error", 32'(error), 32'd0);
         chk("err_no_write", 32'(n_we), 32'd0);
         err_flag = 1'b0;
         tick();
      end

      // Reset in the middle of DIV_WAIT, then a stray done_div must be ignored.
      begin
         int c;
         op = 3'd7; go = 1'b1;
         tick();
         go = 1'b0;
         c = 0;
         while (cs != 4'(ST_DIV_WAIT) && c < 20) begin
            tick();
            c++;
         end
         chk("rstmid_reach_divwait", 32'(cs), 32'(ST_DIV_WAIT));
         tick(); tick();
         rst = 1'b0;
         tick();
         chk("rstmid_outputs", 32'(act_vec), 32'd0);
         rst = 1'b1; done_div = 1'b1;
         tick();
         done_div = 1'b0;
         chk("rstmid_stray_done", 32'(act_vec), 32'd0);
      end

      // Divide with done_div never returned.
      begin
         int n_wait, n_we;
         logic saw_err;
         n_wait = 0; n_we = 0; saw_err = 1'b0;
         op = 3'd7; go = 1'b1;
         tick();
         go = 1'b0;
`ifdef CALCSYS_CTRL_TIMEOUT_EN
         for (int c = 1; c <= 60 && !saw_err; c++) begin
            if (cs == 4'(ST_DIV_WAIT)) n_wait++;
            if (hi_en || lo_en) n_we++;
            if (cs == 4'(ST_ERR)) saw_err = 1'b1;
            else tick();
         end
         chk("timeout_err_reached", 32'(saw_err), 32'd1);
         chk("timeout_wait_cycles", 32'(n_wait), 32'(TMO));
         chk("timeout_no_write", 32'(n_we), 32'd0);
         tick();
         chk("timeout_back_idle", 32'(cs), 32'(ST_IDLE));
`else
         for (int c = 1; c <= 60; c++) begin
            if (cs == 4'(ST_DIV_WAIT)) n_wait++;
            if (cs == 4'(ST_ERR)) saw_err = 1'b1;
            if (c < 60) tick();
         end
         chk("nowd_wait_cycles", 32'(n_wait), 32'd57);
         chk("nowd_no_err", 32'(saw_err), 32'd0);
         chk("nowd_still_waiting", 32'(cs), 32'(ST_DIV_WAIT));
         done_div = 1'b1;
         tick();
         done_div = 1'b0;
         chk("nowd_write", 32'(act_vec), 32'(exp_vec(ST_WRITE, 3'd7)));
         tick(); tick();
         chk("nowd_back_idle", 32'(cs), 32'(ST_IDLE));
`endif
      end

      // Randomized transactions against a per-cycle schedule built from the rules.
      for (int t = 0; t < 60; t++) begin
         logic [2:0] o;
         int g, gap, d, k;
         bit is_err;
         o = 3'($urandom_range(0, 7));
         g = $urandom_range(1, 3);
         d = $urandom_range(1, 8);
         gap = $urandom_range(0, 3);
         is_err = ($urandom_range(0, 5) == 0);
         for (int i = 0; i < gap; i++) push(ST_IDLE, 0, 0, 0, 1'($urandom_range(0, 1)));
         if (is_err) begin
            push(ST_IDLE, 1, 0, 0, 1);
            for (int i = 1; i < g; i++) push(ST_ERR, 1, 0, 0, 1'($urandom_range(0, 1)));
            push(ST_ERR, 0, 0, 0, 1'($urandom_range(0, 1)));
         end else begin
            push(ST_IDLE, 1, 0, 0, 0);
            k = 1;
            push(ST_LOAD, k < g, 0, 0, 1'($urandom_range(0, 1))); k++;
            push(ST_DECODE, k < g, 0, 0, 1'($urandom_range(0, 1))); k++;
            if (o >= 3'd2 && o <= 3'd5) begin
               push(ST_CALC_GO, 0, 0, 0, 0);
               for (int i = 1; i <= d; i++) push(ST_CALC_WAIT, 0, i == d, 0, 0);
            end else if (o == 3'd6) begin
               for (int i = 0; i < MUL_LAT; i++) push(ST_MUL_WAIT, 0, 0, 0, 0);
            end else if (o == 3'd7) begin
               push(ST_DIV_GO, 0, 0, 0, 0);
               for (int i = 1; i <= d; i++) push(ST_DIV_WAIT, 0, 0, i == d, 0);
            end
            push(ST_WRITE, 0, 0, 0, 0);
            push(ST_DONE, 0, 0, 0, 1'($urandom_range(0, 1)));
         end
         op = o;
         while (sched.size() > 0) begin
            cyc_t e;
            e = sched.pop_front();
            chk($sformatf("rand_t%0d_%s", t, e.st.name()), 32'(act_vec), 32'(exp_vec(e.st, o)));
            go = e.g; done_calc = e.dc; done_div = e.dd; err_flag = e.ef;
            tick();
         end
         go = 1'b0; done_calc = 1'b0; done_div = 1'b0; err_flag = 1'b0;
         chk($sformatf("rand_t%0d_end_idle", t), 32'(act_vec), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/calcsys_control_unit.md
CALCSYS_CONTROL_UNIT -- requirements
Module: calcsys_control_unit

Interface
REQ-001 SHALL have parameter MUL_LAT, default 2: multiplier wait cycles before write-back (1..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16: watchdog limit per wait state (macro-gated, see REQ-026).
REQ-003 SHALL have ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; synchronous and active-low.
- go  in  1  start request from operator.
- op  in  3  latched opcode from datapath OP_out.
- done_calc  in  1  small-calculator completion.
- done_div  in  1  divider completion.
- err_flag  in  1  datapath divide-by-zero indication, valid combinationally in IDLE.
- x_en, y_en, f_en  out  1 each  operand/opcode register enables.
- hi_en, lo_en  out  1 each  result register enables.
- sel_lo, sel_hi  out  2 each  result mux selects.
- op_calc  out  2  small-calculator op.
- sel_p  out  1  pass mux select (0=X, 1=Y).
- go_calc, go_div  out  1 each  sub-unit start pulses.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- error  out  1  high while in ERR.
- cs  out  4  current state encoding.

Function
REQ-004 SHALL implement states IDLE, LOAD, DECODE, CALC_GO, CALC_WAIT, MUL_WAIT, DIV_GO, DIV_WAIT, WRITE, DONE, ERR.
REQ-005 SHALL sample go only in IDLE; go while busy SHALL be ignored.
REQ-006 IDLE: go=1 and err_flag=1 -> ERR; go=1 and err_flag=0 -> LOAD; else stay.
REQ-007 LOAD SHALL assert x_en, y_en, f_en for exactly one cycle, then -> DECODE.
REQ-008 Opcode map: 000 pass X; 001 pass Y; 010 add; 011 sub; 100 and; 101 xor; 110 multiply; 111 divide.
REQ-009 DECODE: pass -> WRITE; add/sub/and/xor -> CALC_GO; multiply -> MUL_WAIT; divide -> DIV_GO.
REQ-010 CALC_GO SHALL assert go_calc for one cycle, then -> CALC_WAIT; CALC_WAIT -> WRITE on done_calc=1.
REQ-011 op_calc SHALL be op[1:0] minus 2 (mod 4): add=00, sub=01, and=10, xor=11.
REQ-012 MUL_WAIT SHALL stay exactly MUL_LAT cycles (internal 4-bit counter), then -> WRITE.
REQ-013 DIV_GO SHALL assert go_div for one cycle, then -> DIV_WAIT; DIV_WAIT -> WRITE on done_div=1.
REQ-014 Selects SHALL be driven from op in DECODE through WRITE and be 0 in all other states: pass sel_lo=00, sel_hi=00, sel_p=op[0]; calc sel_lo=sel_hi=01; multiply 10; divide 11.
REQ-015 WRITE SHALL assert hi_en and lo_en for exactly one cycle, then -> DONE.
REQ-016 DONE SHALL assert done for one cycle, then -> IDLE unconditionally.
REQ-017 ERR SHALL assert error and hold until go=0, then -> IDLE; hi_en/lo_en SHALL never assert on an error path.
REQ-018 Pass latency: go high in IDLE at cycle 0 -> LOAD c1, DECODE c2, WRITE c3, done=1 in c4.
REQ-019 A done_calc/done_div arriving in a state other than its wait state SHALL be ignored.
REQ-020 All enables and go pulses SHALL be Moore outputs, decoded from state only (plus op for selects).
REQ-021 cs SHALL equal the package state encoding of the current state.

Reset
REQ-022 rst=0 at a clock edge SHALL force IDLE from any state, including mid-operation.
REQ-023 After reset, all outputs SHALL be 0 and cs SHALL be the IDLE code (0000); the MUL_WAIT counter SHALL be 0.
REQ-024 rst SHALL be sampled only on clk rising edges; there SHALL be no asynchronous path.

Configuration
REQ-025 Macro CALCSYS_CTRL_TIMEOUT_EN SHALL gate a watchdog counter.
REQ-026 Defined: remaining TIMEOUT_CYCLES consecutive cycles in CALC_WAIT or DIV_WAIT without the done input SHALL -> ERR; the counter SHALL clear on each wait-state entry.
REQ-027 Undefined: no watchdog logic; wait states SHALL wait indefinitely.

Structure
REQ-028 Shared package calcsys_pkg SHALL hold the state enum/encodings, opcode constants and select codes.
REQ-029 One combinational sub-module, calcsys_op_decode, SHALL map op to op class, sel_lo, sel_hi, sel_p and op_calc.

Verification
REQ-030 Reset mid-DIV_WAIT (rst=0 for one edge) -> next cycle cs=0000, all outputs 0.
REQ-031 op=000, go pulse -> hi_en=lo_en=1 in c3, done=1 in c4, sel_p=0 during WRITE.
REQ-032 op=010, done_calc returned 3 cycles after go_calc -> op_calc=00, sel_lo=sel_hi=01 during WRITE, exactly one done pulse.
REQ-033 op=110, MUL_LAT=2 -> exactly 2 cycles in MUL_WAIT, sel_lo=sel_hi=10 during WRITE.
REQ-034 err_flag=1 with go=1 -> ERR, error=1 while go held, no hi_en/lo_en, IDLE one cycle after go falls.
REQ-035 With CALCSYS_CTRL_TIMEOUT_EN defined, op=111 and done_div never asserted -> ERR after 16 cycles in DIV_WAIT.
